// File: rtl/cos_pkg.sv
// rtl/cos_pkg.sv - shared constants, coefficient table and FSM state type for the cosine datapath
//
// Purpose: single source for the coefficient width/depth, the coefficient
//          contents and the streaming FSM state encoding.
// Ports:   none (package).
package cos_pkg;

  localparam int COEF_W     = 16;
  localparam int COEF_DEPTH = 8;

  // Signed fixed-point series coefficients, entry 0 first.
  localparam logic [COEF_W-1:0] COEF_TABLE [COEF_DEPTH] = '{
    16'hFC00,
    16'hFF55,
    16'h0400,
    16'hFFDB,
    16'h0011,
    16'hFFF0,
    16'h0007,
    16'hFFFD
  };

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

endpackage

// File: rtl/coef_table.sv
// rtl/coef_table.sv - purely combinational indexed coefficient lookup
//
// Purpose: returns the coefficient for i_idx; any index outside the table
//          (or beyond the package contents) reads as zero.
// Ports:
//   i_idx   in  AW+1   lookup index (one extra bit so out-of-range is expressible)
//   o_data  out WIDTH  coefficient, zero when i_idx is out of range
module coef_table
  import cos_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic [AW:0]      i_idx,
  output logic [WIDTH-1:0] o_data
);

  // Only entries that exist both in this instance and in the package table.
  localparam int N_ENT = (DEPTH < COEF_DEPTH) ? DEPTH : COEF_DEPTH;

  always_comb begin
    o_data = '0;
    for (int i = 0; i < N_ENT; i++) begin
      if (i_idx == (AW+1)'(i)) begin
        o_data = WIDTH'($signed(COEF_TABLE[i]));
      end
    end
  end

endmodule

// File: rtl/coef_stream_rom.sv
// rtl/coef_stream_rom.sv - coefficient store streaming a contiguous run over valid/ready
//
// Purpose: on a valid start, streams entries base..base+len-1 one per cycle
//          with backpressure; malformed requests are rejected with an err pulse.
// Ports:
//   clk        in  1      clock, rising edge
//   rst        in  1      asynchronous active-high reset
//   start      in  1      request pulse, sampled only in IDLE
//   base       in  AW     first entry index
//   len        in  AW+1   entries to stream, 1..DEPTH
//   busy       out 1      high while streaming
//   out_valid  out 1      beat available
//   out_ready  in  1      consumer accepts beat
//   out_data   out WIDTH  coefficient at out_idx
//   out_idx    out AW     index of current beat
//   out_last   out 1      final beat of run
//   err        out 1      one-cycle pulse on rejected start
module coef_stream_rom
  import cos_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [$clog2(DEPTH)-1:0]   base,
  input  logic [$clog2(DEPTH):0]     len,
  output logic                       busy,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH)-1:0]   out_idx,
  output logic                       out_last,
  output logic                       err
);

  localparam int AW = $clog2(DEPTH);

  state_t            r_state;
  logic [AW-1:0]     r_idx;
  logic [AW:0]       r_rem;
  logic [WIDTH-1:0]  r_data;
  logic              r_valid;
  logic              r_last;
  logic              r_busy;
  logic              r_err;

  logic [AW+1:0]     w_sum;
  logic              w_req_bad;
  logic              w_handshake;
  logic [AW:0]       w_next_idx;
  logic [WIDTH-1:0]  w_lut_data;

  // Two extra bits so base+len never wraps before the compare.
  assign w_sum       = {2'b00, base} + {1'b0, len};
  assign w_req_bad   = (len == '0) || (w_sum > (AW+2)'(DEPTH));
  assign w_handshake = r_valid & out_ready;

  // The lookup follows the index that will be registered next: base when
  // launching a run, idx+1 when advancing within one.
  assign w_next_idx  = (r_state == IDLE) ? {1'b0, base}
                                         : ({1'b0, r_idx} + (AW+1)'(1));

  coef_table #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_coef_table (
    .i_idx  (w_next_idx),
    .o_data (w_lut_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_rem   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            if (w_req_bad) begin
              r_err <= 1'b1;
            end else begin
              r_state <= STREAM;
              r_idx   <= base;
              r_rem   <= len;
              r_data  <= w_lut_data;
              r_last  <= (len == (AW+1)'(1));
              r_valid <= 1'b1;
              r_busy  <= 1'b1;
            end
          end
        end
        STREAM: begin
          // start is deliberately ignored here: no queueing, no err.
          if (w_handshake) begin
            if (r_last) begin
              r_state <= IDLE;
              r_valid <= 1'b0;
              r_last  <= 1'b0;
              r_busy  <= 1'b0;
            end else begin
              r_idx  <= r_idx + AW'(1);
              r_rem  <= r_rem - (AW+1)'(1);
              r_data <= w_lut_data;
              r_last <= (r_rem == (AW+1)'(2));
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_idx   = r_idx;
  assign out_last  = r_last;
  assign err       = r_err;

endmodule

// File: tb/tb_coef_stream_rom.sv
// tb/tb_coef_stream_rom.sv - directed self-checking bench for coef_stream_rom
module tb_coef_stream_rom;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  base;
  logic [3:0]  len;
  logic        busy;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [2:0]  out_idx;
  logic        out_last;
  logic        err;

  int checks;
  int errors;

  logic [15:0] exp_tab [8] = '{16'hFC00, 16'hFF55, 16'h0400, 16'hFFDB,
                               16'h0011, 16'hFFF0, 16'h0007, 16'hFFFD};

  coef_stream_rom #(.WIDTH(16), .DEPTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base      (base),
    .len       (len),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Called at a negedge: drives start now, so it is sampled at the next edge.
  task automatic run_burst(input int b, input int l, input logic [15:0] rp,
                           input bit poke, input int exp_cyc);
    int          n;
    int          cyc;
    bit          done;
    bit          errs;
    logic        stall;
    logic [15:0] pd;
    logic [2:0]  pi;
    logic [15:0] ed;
    n = 0; cyc = 0; done = 0; errs = 0; stall = 0; pd = '0; pi = '0;
    start = 1'b1; base = 3'(b); len = 4'(l); out_ready = rp[0];
    @(negedge clk);
    start = 1'b0;
    chk("first_valid", 32'(out_valid), 32'd1);
    for (int c = 0; c < 40 && !done; c++) begin
      out_ready = (c < 16) ? rp[4'(c)] : 1'b1;
      if (poke && c == 1) begin
        start = 1'b1; base = 3'd0; len = 4'd2;
      end else begin
        start = 1'b0;
      end
      if (err) errs = 1;
      if (busy) cyc++;
      if (out_valid) begin
        if (stall) begin
          chk("hold_data", 32'(out_data), 32'(pd));
          chk("hold_idx", 32'(out_idx), 32'(pi));
        end
        ed = (b + n < 8) ? exp_tab[b + n] : 16'hxxxx;
        chk("beat_idx", 32'(out_idx), 32'(b + n));
        chk("beat_data", 32'(out_data), 32'(ed));
        chk("beat_last", 32'(out_last), 32'(n == l - 1));
        stall = !out_ready;
        pd = out_data;
        pi = out_idx;
        if (out_ready) begin
          n++;
          if (out_last) done = 1;
        end
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk("busy_after", 32'(busy), 32'd0);
    chk("valid_after", 32'(out_valid), 32'd0);
    chk("beat_count", 32'(n), 32'(l));
    chk("no_err", 32'(errs), 32'd0);
    if (exp_cyc > 0) chk("stream_cycles", 32'(cyc), 32'(exp_cyc));
  endtask

  task automatic reject(input int b, input int l);
    start = 1'b1; base = 3'(b); len = 4'(l); out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("rej_err", 32'(err), 32'd1);
    chk("rej_valid", 32'(out_valid), 32'd0);
    chk("rej_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("rej_err_once", 32'(err), 32'd0);
    chk("rej_no_beat", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("rej_no_beat2", 32'(out_valid), 32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1; start = 1'b0; base = '0; len = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_idx", 32'(out_idx), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Full run, constant ready: 8 beats in 8 cycles.
    run_burst(0, 8, 16'hFFFF, 1'b0, 8);
    @(negedge clk);

    // Backpressure with ready 1,0,0,1,0,1.
    run_burst(2, 3, 16'hFFE9, 1'b0, 6);
    @(negedge clk);

    // Rejects and the tightest legal request.
    reject(6, 3);
    reject(3, 0);
    run_burst(7, 1, 16'hFFFF, 1'b0, 1);
    @(negedge clk);

    // start during a run is ignored.
    run_burst(1, 4, 16'hFFFF, 1'b1, 4);

    // Back-to-back: next start sampled at the edge right after busy falls.
    run_burst(1, 2, 16'hFFFF, 1'b0, 2);
    run_burst(4, 2, 16'hFFFF, 1'b0, 2);
    @(negedge clk);

    // Reset mid-stream aborts the run.
    start = 1'b1; base = 3'd0; len = 4'd8; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("pre_rst_idx", 32'(out_idx), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_data", 32'(out_data), 32'd0);
    chk("mid_rst_idx", 32'(out_idx), 32'd0);
    chk("mid_rst_last", 32'(out_last), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("post_rst_idle", 32'({busy, out_valid, err}), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
